inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- PC generator and fetch buffer directly upstream of the instruction ROM.
- Drives the ROM chip-enable and byte address, and captures the returned 32-bit instruction (combinational ROM, same-cycle data) together with its PC into a small FIFO.
- Hands {pc, inst} pairs to the decode stage over a valid/ready handshake.
- Handles pipeline stall and branch/jump redirect with buffer flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset (word aligned).
- FIFO_DEPTH, 2, buffer entries; power of two, ≥2.
- ADDR_W, 32, PC / ROM address width.
- INST_W, 32, instruction width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_i  in  1  from control: inhibit new fetches this cycle.
- branch_flag_i  in  1  redirect request from execute.
- branch_target_i  in  ADDR_W  redirect byte address.
- rom_ce_o  out  1  ROM chip enable.
- rom_addr_o  out  ADDR_W  ROM byte address (current PC).
- rom_inst_i  in  INST_W  instruction returned by ROM, same cycle.
- id_valid_o  out  1  buffer head valid.
- id_ready_i  in  1  decode accepts head this cycle.
- id_pc_o  out  ADDR_W  PC of head entry.
- id_inst_o  out  INST_W  instruction of head entry.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset:
  - pc ← RESET_PC; en_q ← 0; FIFO count, rd_ptr, wr_ptr ← 0.
  - rom_ce_o = 0, id_valid_o = 0, id_pc_o = 0, id_inst_o = 0.
- en_q: becomes 1 on the first clk edge after rst deasserts and stays 1. rom_ce_o = en_q.
- rom_addr_o = pc, always.
- pop = id_valid_o && id_ready_i.
- fire = en_q && !stall_i && !branch_flag_i && (count < FIFO_DEPTH || pop).
- On fire: write {pc, rom_inst_i} at wr_ptr; wr_ptr++; pc ← pc + 4 (mod 2^ADDR_W, 32'hFFFF_FFFC wraps to 0).
- On pop: rd_ptr++.
- count ← count + fire − pop. Simultaneous fire and pop at full is legal; count is unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- Redirect (branch_flag_i = 1) has priority over everything else:
  - pc ← {branch_target_i[ADDR_W-1:2], 2'b00}.
  - count, rd_ptr, wr_ptr ← 0; no fetch that cycle.
  - A pop in the same cycle is a completed handshake for the head (decode owns it); the entry is discarded from the buffer regardless.
  - First fetch from the target occurs the next cycle (1-cycle redirect bubble).
  - Redirect is honoured even with stall_i = 1 or en_q = 0.
- Stall only blocks fire; pc holds; buffered entries still drain via pop.
- Output mapping:
  - id_valid_o = (count != 0).
  - id_pc_o / id_inst_o = head entry when valid, otherwise all zeros.
  - Outputs depend only on registers, never on rom_inst_i in the same cycle.
- Latency:
  - An instruction fetched in cycle N is visible on id_* in cycle N+1.
  - With id_ready_i held high, throughput is 1 instruction/cycle.
- Decode rule: decode must not depend on id_pc_o/id_inst_o when id_valid_o = 0.
- rst mid-operation overrides branch, stall and pop; buffered entries are lost.

Test Plan:
- Reset and streaming:
  - Stimulus: assert rst 2 cycles, release; id_ready_i = 1; ROM holds inst[k] = 32'h1000_0000 + k.
  - Required: rom_ce_o = 0 in the first post-reset cycle. Then rom_addr_o steps 0, 4, 8, …; id_valid_o rises one cycle after the first fetch; id_pc_o/id_inst_o = 0/32'h1000_0000, 4/32'h1000_0001, … back-to-back.
- Back-pressure fill:
  - Stimulus: id_ready_i = 0 from the start.
  - Required: exactly 2 fetches (PC 0, 4), then rom_addr_o holds 8; id_pc_o stays 0.
  - Then raise id_ready_i: entries drain in order 0, 4, 8, … with no gap or duplicate.
- Full plus simultaneous pop:
  - Stimulus: buffer full, id_ready_i = 1 for one cycle.
  - Required: fetch at PC 8 occurs in that same cycle; count stays 2.
- Redirect:
  - Stimulus: with 2 entries buffered, pulse branch_flag_i with branch_target_i = 32'h0000_0102.
  - Required: next cycle id_valid_o = 0 and rom_addr_o = 32'h100; the cycle after, id_pc_o = 32'h100.
- Stall:
  - Stimulus: hold stall_i 3 cycles with 1 entry buffered and id_ready_i = 1.
  - Required: the entry drains, rom_addr_o is frozen, id_valid_o = 0 in cycles 2–3, and fetch resumes at the frozen PC.
- Wrap and reset mid-run:
  - Stimulus: redirect to 32'hFFFF_FFFC.
  - Required: the next fetched PC is 0. Asserting rst then clears id_valid_o and returns rom_addr_o to RESET_PC on the next edge.

Source files
------------

// File: rtl/inst_fetch.sv
// PC generator and fetch buffer feeding decode from a combinational ROM.
// Captures {pc, inst} pairs into a small FIFO; redirect flushes the buffer.
module inst_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter int          ADDR_W     = 32,
    parameter int          INST_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [INST_W-1:0] rom_inst_i,
    output logic              id_valid_o,
    input  logic              id_ready_i,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0] id_inst_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [ADDR_W-1:0] pc;
    logic              en_q;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    logic [ADDR_W-1:0] buf_pc   [FIFO_DEPTH];
    logic [INST_W-1:0] buf_inst [FIFO_DEPTH];

    logic pop;
    logic fire;
    logic full;

    assign full = (count == CNT_W'(FIFO_DEPTH));
    assign pop  = id_valid_o && id_ready_i;
    assign fire = en_q && !stall_i && !branch_flag_i && (!full || pop);

    assign rom_ce_o   = en_q;
    assign rom_addr_o = pc;

    // A full buffer still accepts a fetch when the head leaves the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= ADDR_W'(RESET_PC);
            en_q   <= 1'b0;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            en_q <= 1'b1;
            if (branch_flag_i) begin
                pc     <= branch_target_i & ~ADDR_W'(3);
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (fire) begin
                    pc     <= pc + ADDR_W'(4);
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= count + CNT_W'(fire) - CNT_W'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fire) begin
            buf_pc[wr_ptr]   <= pc;
            buf_inst[wr_ptr] <= rom_inst_i;
        end
    end

    assign id_valid_o = (count != '0);
    assign id_pc_o    = id_valid_o ? buf_pc[rd_ptr]   : '0;
    assign id_inst_o  = id_valid_o ? buf_inst[rd_ptr] : '0;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: streaming, back-pressure, redirect,
// stall, address wrap and mid-run reset against a modelled ROM.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // ROM image: word k holds 32'h1000_0000 + k
    assign rom_inst = 32'h1000_0000 + (rom_addr >> 2);

    inst_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall),
        .branch_flag_i   (branch_flag),
        .branch_target_i (branch_target),
        .rom_ce_o        (rom_ce),
        .rom_addr_o      (rom_addr),
        .rom_inst_i      (rom_inst),
        .id_valid_o      (id_valid),
        .id_ready_i      (id_ready),
        .id_pc_o         (id_pc),
        .id_inst_o       (id_inst)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        stall = 1'b0;
        branch_flag = 1'b0;
        branch_target = '0;
        id_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (rom_ce !== 1'b0) begin
            errors++;
            $display("FAIL reset_ce got %0h exp 0", rom_ce);
        end
        checks++;
        if (id_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %0h exp 0", id_valid);
        end
        checks++;
        if (id_pc !== 32'h0 || id_inst !== 32'h0) begin
            errors++;
            $display("FAIL reset_head got %h/%h exp 0/0", id_pc, id_inst);
        end
        checks++;
        if (rom_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_addr got %h exp 0", rom_addr);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (rom_ce !== 1'b0) begin
            errors++;
            $display("FAIL first_cycle_ce got %0h exp 0", rom_ce);
        end
    endtask

    task automatic test_streaming();
        tick();
        checks++;
        if (rom_ce !== 1'b1 || rom_addr !== 32'h0 || id_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_start got ce=%0h addr=%h v=%0h exp 1/0/0",
                     rom_ce, rom_addr, id_valid);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (id_valid !== 1'b1 || id_pc !== 32'(4 * k) ||
                id_inst !== 32'h1000_0000 + 32'(k) ||
                rom_addr !== 32'(4 * k + 4)) begin
                errors++;
                $display("FAIL stream_%0d got v=%0h pc=%h inst=%h addr=%h exp 1/%h/%h/%h",
                         k, id_valid, id_pc, id_inst, rom_addr,
                         32'(4 * k), 32'h1000_0000 + 32'(k), 32'(4 * k + 4));
            end
        end
    endtask

    task automatic test_backpressure();
        rst = 1'b1;
        id_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        tick();
        tick();
        checks++;
        if (rom_addr !== 32'h8) begin
            errors++;
            $display("FAIL bp_addr_hold got %h exp 00000008", rom_addr);
        end
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_inst !== 32'h1000_0000) begin
            errors++;
            $display("FAIL bp_head got v=%0h pc=%h inst=%h exp 1/0/10000000",
                     id_valid, id_pc, id_inst);
        end
    endtask

    task automatic test_full_pop();
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        checks++;
        if (rom_addr !== 32'hC || id_pc !== 32'h4 || id_inst !== 32'h1000_0001) begin
            errors++;
            $display("FAIL full_pop got addr=%h pc=%h inst=%h exp c/4/10000001",
                     rom_addr, id_pc, id_inst);
        end
        tick();
        checks++;
        if (rom_addr !== 32'hC || id_valid !== 1'b1 || id_pc !== 32'h4) begin
            errors++;
            $display("FAIL full_still got addr=%h v=%0h pc=%h exp c/1/4",
                     rom_addr, id_valid, id_pc);
        end
        id_ready = 1'b1;
        for (int k = 2; k < 5; k++) begin
            tick();
            checks++;
            if (id_valid !== 1'b1 || id_pc !== 32'(4 * k) ||
                id_inst !== 32'h1000_0000 + 32'(k)) begin
                errors++;
                $display("FAIL drain_%0d got v=%0h pc=%h inst=%h exp 1/%h",
                         k, id_valid, id_pc, id_inst, 32'(4 * k));
            end
        end
    endtask

    task automatic test_redirect();
        id_ready = 1'b0;
        branch_flag = 1'b1;
        branch_target = 32'h0000_0102;
        tick();
        branch_flag = 1'b0;
        checks++;
        if (id_valid !== 1'b0 || rom_addr !== 32'h100 || id_pc !== 32'h0) begin
            errors++;
            $display("FAIL redirect_flush got v=%0h addr=%h pc=%h exp 0/100/0",
                     id_valid, rom_addr, id_pc);
        end
        tick();
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h100 ||
            id_inst !== 32'h1000_0040 || rom_addr !== 32'h104) begin
            errors++;
            $display("FAIL redirect_fetch got v=%0h pc=%h inst=%h addr=%h exp 1/100/10000040/104",
                     id_valid, id_pc, id_inst, rom_addr);
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        id_ready = 1'b1;
        tick();
        checks++;
        if (id_valid !== 1'b0 || rom_addr !== 32'h104) begin
            errors++;
            $display("FAIL stall_c2 got v=%0h addr=%h exp 0/104", id_valid, rom_addr);
        end
        tick();
        checks++;
        if (id_valid !== 1'b0 || rom_addr !== 32'h104) begin
            errors++;
            $display("FAIL stall_c3 got v=%0h addr=%h exp 0/104", id_valid, rom_addr);
        end
        tick();
        stall = 1'b0;
        checks++;
        if (rom_addr !== 32'h104) begin
            errors++;
            $display("FAIL stall_hold got addr=%h exp 104", rom_addr);
        end
        tick();
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h104 ||
            id_inst !== 32'h1000_0041 || rom_addr !== 32'h108) begin
            errors++;
            $display("FAIL stall_resume got v=%0h pc=%h inst=%h addr=%h exp 1/104/10000041/108",
                     id_valid, id_pc, id_inst, rom_addr);
        end
    endtask

    task automatic test_wrap_reset();
        branch_flag = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        tick();
        branch_flag = 1'b0;
        checks++;
        if (rom_addr !== 32'hFFFF_FFFC || id_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_redirect got addr=%h v=%0h exp fffffffc/0",
                     rom_addr, id_valid);
        end
        tick();
        checks++;
        if (id_pc !== 32'hFFFF_FFFC || id_inst !== 32'h4FFF_FFFF || rom_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_top got pc=%h inst=%h addr=%h exp fffffffc/4fffffff/0",
                     id_pc, id_inst, rom_addr);
        end
        tick();
        checks++;
        if (id_pc !== 32'h0 || id_inst !== 32'h1000_0000 || rom_addr !== 32'h4) begin
            errors++;
            $display("FAIL wrap_zero got pc=%h inst=%h addr=%h exp 0/10000000/4",
                     id_pc, id_inst, rom_addr);
        end
        rst = 1'b1;
        branch_flag = 1'b1;
        branch_target = 32'h0000_0200;
        stall = 1'b1;
        tick();
        checks++;
        if (id_valid !== 1'b0 || rom_addr !== 32'h0 || rom_ce !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got v=%0h addr=%h ce=%0h exp 0/0/0",
                     id_valid, rom_addr, rom_ce);
        end
        rst = 1'b0;
        branch_flag = 1'b0;
        stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_full_pop();
        test_redirect();
        test_stall();
        test_wrap_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
